// File: rtl/change_dispenser.sv
// Greedy change dispenser: turns a change amount into single-coin eject requests
// to a four-tube hopper using a four-phase req/ack handshake with an ack timeout.
module change_dispenser #(
    parameter logic [6:0]  COIN_A_VALUE = 7'd10,
    parameter logic [6:0]  COIN_B_VALUE = 7'd5,
    parameter logic [6:0]  COIN_C_VALUE = 7'd2,
    parameter logic [6:0]  COIN_D_VALUE = 7'd1,
    parameter logic [15:0] ACK_TIMEOUT  = 16'd1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_change_valid,
    input  logic [6:0] i_change_amount,
    input  logic [3:0] i_tube_empty,
    input  logic       i_eject_ack,
    input  logic       i_clear,
    output logic       o_busy,
    output logic       o_eject_req,
    output logic [1:0] o_eject_sel,
    output logic       o_done,
    output logic       o_error,
    output logic [6:0] o_remaining,
    output logic [6:0] o_coin_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_EJECT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  remaining_q, remaining_d;
    logic [6:0]  coin_count_q, coin_count_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  elig_s;

    function automatic logic [6:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    coin_value = COIN_A_VALUE;
            2'd1:    coin_value = COIN_B_VALUE;
            2'd2:    coin_value = COIN_C_VALUE;
            2'd3:    coin_value = COIN_D_VALUE;
            default: coin_value = 7'd0;
        endcase
    endfunction

    // Tube n is eligible when it is stocked and its coin fits in the amount owed.
    always_comb begin
        elig_s[0] = (COIN_A_VALUE <= remaining_q) && !i_tube_empty[0];
        elig_s[1] = (COIN_B_VALUE <= remaining_q) && !i_tube_empty[1];
        elig_s[2] = (COIN_C_VALUE <= remaining_q) && !i_tube_empty[2];
        elig_s[3] = (COIN_D_VALUE <= remaining_q) && !i_tube_empty[3];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_count_d = coin_count_q;
        sel_d        = sel_q;
        timer_d      = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (i_change_valid) begin
                    remaining_d  = i_change_amount;
                    coin_count_d = 7'd0;
                    timer_d      = 16'd0;
                    state_d      = (i_change_amount == 7'd0) ? ST_DONE : ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                timer_d = 16'd0;
                if (remaining_q == 7'd0) begin
                    state_d = ST_DONE;
                end else if (elig_s[0]) begin
                    sel_d   = 2'd0;
                    state_d = ST_EJECT;
                end else if (elig_s[1]) begin
                    sel_d   = 2'd1;
                    state_d = ST_EJECT;
                end else if (elig_s[2]) begin
                    sel_d   = 2'd2;
                    state_d = ST_EJECT;
                end else if (elig_s[3]) begin
                    sel_d   = 2'd3;
                    state_d = ST_EJECT;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_EJECT: begin
                // Ack is checked first so an ack on the final timeout cycle is accepted.
                if (i_eject_ack) begin
                    remaining_d  = remaining_q - coin_value(sel_q);
                    coin_count_d = coin_count_q + 7'd1;
                    state_d      = ST_RELEASE;
                end else if (timer_q == (ACK_TIMEOUT - 16'd1)) begin
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                if (!i_eject_ack) begin
                    timer_d = 16'd0;
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (i_clear) begin
                    remaining_d = 7'd0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 7'd0;
            coin_count_q <= 7'd0;
            sel_q        <= 2'd0;
            timer_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_count_q <= coin_count_d;
            sel_q        <= sel_d;
            timer_q      <= timer_d;
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_eject_req  = (state_q == ST_EJECT);
    assign o_eject_sel  = sel_q;
    assign o_done       = (state_q == ST_DONE);
    assign o_error      = (state_q == ST_ERROR);
    assign o_remaining  = remaining_q;
    assign o_coin_count = coin_count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: expected tube sequences are queued
// when a request is issued and compared against the eject requests observed.
module tb_change_dispenser;

    localparam int ACK_TO = 1000;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_change_valid = 1'b0;
    logic [6:0] i_change_amount = 7'd0;
    logic [3:0] i_tube_empty = 4'b0000;
    logic       i_eject_ack = 1'b0;
    logic       i_clear = 1'b0;
    logic       o_busy, o_eject_req, o_done, o_error;
    logic [1:0] o_eject_sel;
    logic [6:0] o_remaining, o_coin_count;

    int n_checks = 0;
    int n_fail = 0;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    // Results of the most recent capture run.
    int  cap_cycles;
    int  cap_req_cycles;
    int  cap_done_cnt;
    bit  cap_timeout;
    bit  hop_follow = 1'b1;

    change_dispenser dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_change_valid (i_change_valid),
        .i_change_amount(i_change_amount),
        .i_tube_empty   (i_tube_empty),
        .i_eject_ack    (i_eject_ack),
        .i_clear        (i_clear),
        .o_busy         (o_busy),
        .o_eject_req    (o_eject_req),
        .o_eject_sel    (o_eject_sel),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_remaining    (o_remaining),
        .o_coin_count   (o_coin_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic strobe(input logic [6:0] amt);
        @(negedge i_clk);
        i_change_valid  = 1'b1;
        i_change_amount = amt;
        @(negedge i_clk);
        i_change_valid  = 1'b0;
    endtask

    // Samples at each falling edge, plays the hopper and records rising eject requests.
    task automatic run_capture(input int budget);
        logic prev_req;
        prev_req       = 1'b0;
        cap_cycles     = 0;
        cap_req_cycles = 0;
        cap_done_cnt   = 0;
        cap_timeout    = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (o_eject_req) cap_req_cycles++;
            if (o_eject_req && !prev_req) obs_q.push_back(o_eject_sel);
            prev_req = o_eject_req;
            if (o_done) cap_done_cnt++;
            i_eject_ack = hop_follow ? o_eject_req : 1'b0;
            if (o_done || o_error) begin
                cap_cycles  = c;
                cap_timeout = 1'b0;
                break;
            end
            @(negedge i_clk);
        end
        i_eject_ack = hop_follow ? o_eject_req : 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        n_checks++;
        if ({o_busy, o_eject_req, o_done, o_error} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {o_busy, o_eject_req, o_done, o_error});
        end
        n_checks++;
        if ({o_remaining, o_coin_count, o_eject_sel} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: rem=%0d cnt=%0d sel=%0d expected 0", o_remaining, o_coin_count, o_eject_sel);
        end
    endtask

    // Issues a request and compares the observed tube sequence with the queued expectation.
    task automatic run_sequence(input string name, input logic [6:0] amt, input logic [3:0] empty,
                                input int exp_count);
        i_tube_empty = empty;
        obs_q.delete();
        strobe(amt);
        run_capture(400);
        n_checks++;
        if (cap_timeout || cap_done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s_done: timeout=%0d done_pulses=%0d expected 0/1", name, cap_timeout, cap_done_cnt);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_ncoins: got %0d ejects expected %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s_sel: got tube %0d expected %0d", name, o, e);
            end
        end
        exp_q.delete();
        n_checks++;
        if (o_coin_count !== 7'(exp_count) || o_remaining !== 7'd0) begin
            n_fail++;
            $display("FAIL %s_totals: cnt=%0d rem=%0d expected %0d/0", name, o_coin_count, o_remaining, exp_count);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_coin_count !== 7'(exp_count)) begin
            n_fail++;
            $display("FAIL %s_after: done=%b busy=%b cnt=%0d expected 0/0/%0d", name, o_done, o_busy, o_coin_count, exp_count);
        end
    endtask

    task automatic test_greedy();
        exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        run_sequence("greedy37", 7'd37, 4'b0000, 5);
    endtask

    task automatic test_skip_empty();
        for (int i = 0; i < 4; i++) exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        run_sequence("skip23", 7'd23, 4'b0001, 6);
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        run_sequence("b2b7", 7'd7, 4'b0000, 2);
    endtask

    task automatic test_zero();
        i_tube_empty = 4'b0000;
        obs_q.delete();
        strobe(7'd0);
        run_capture(10);
        n_checks++;
        if (cap_timeout || cap_cycles > 1 || cap_done_cnt != 1) begin
            n_fail++;
            $display("FAIL zero_done: timeout=%0d cycles=%0d expected done within 2 cycles", cap_timeout, cap_cycles);
        end
        n_checks++;
        if (cap_req_cycles != 0 || o_coin_count !== 7'd0) begin
            n_fail++;
            $display("FAIL zero_noeject: req_cycles=%0d cnt=%0d expected 0/0", cap_req_cycles, o_coin_count);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pulse: done=%b expected 0", o_done);
        end
    endtask

    task automatic test_no_tube();
        i_tube_empty = 4'b1100;
        strobe(7'd3);
        run_capture(20);
        n_checks++;
        if (cap_timeout || o_error !== 1'b1 || o_busy !== 1'b1 || o_remaining !== 7'd3 || cap_req_cycles != 0) begin
            n_fail++;
            $display("FAIL notube_err: err=%b busy=%b rem=%0d reqs=%0d expected 1/1/3/0", o_error, o_busy, o_remaining, cap_req_cycles);
        end
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_error !== 1'b0 || o_remaining !== 7'd0) begin
            n_fail++;
            $display("FAIL notube_clear: busy=%b err=%b rem=%0d expected 0/0/0", o_busy, o_error, o_remaining);
        end
        i_tube_empty = 4'b0000;
    endtask

    task automatic test_timeout();
        hop_follow = 1'b0;
        strobe(7'd10);
        run_capture(ACK_TO + 20);
        n_checks++;
        if (cap_timeout || cap_req_cycles != ACK_TO || o_error !== 1'b1 || o_remaining !== 7'd10) begin
            n_fail++;
            $display("FAIL timeout: req_cycles=%0d err=%b rem=%0d expected %0d/1/10", cap_req_cycles, o_error, o_remaining, ACK_TO);
        end
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        // Second pass: ack arrives on the last cycle before the timeout fires.
        strobe(7'd10);
        @(negedge i_clk);
        n_checks++;
        if (o_eject_req !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_req: req=%b expected 1", o_eject_req);
        end
        repeat (ACK_TO - 1) @(negedge i_clk);
        n_checks++;
        if (o_eject_req !== 1'b1 || o_error !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_hold: req=%b err=%b expected 1/0", o_eject_req, o_error);
        end
        i_eject_ack = 1'b1;
        @(negedge i_clk);
        hop_follow = 1'b1;
        run_capture(20);
        n_checks++;
        if (cap_timeout || o_error !== 1'b0 || o_done !== 1'b1 || o_remaining !== 7'd0 || o_coin_count !== 7'd1) begin
            n_fail++;
            $display("FAIL edge_ack: err=%b done=%b rem=%0d cnt=%0d expected 0/1/0/1", o_error, o_done, o_remaining, o_coin_count);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid();
        hop_follow  = 1'b0;
        i_eject_ack = 1'b0;
        strobe(7'd15);
        @(negedge i_clk);
        i_change_valid  = 1'b1;
        i_change_amount = 7'd99;
        @(negedge i_clk);
        i_change_valid  = 1'b0;
        n_checks++;
        if (o_eject_req !== 1'b1 || o_remaining !== 7'd15 || o_eject_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL ignore_strobe: req=%b rem=%0d sel=%0d expected 1/15/0", o_eject_req, o_remaining, o_eject_sel);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        n_checks++;
        if ({o_busy, o_eject_req, o_done, o_error} !== 4'b0000 || o_remaining !== 7'd0 || o_coin_count !== 7'd0) begin
            n_fail++;
            $display("FAIL mid_reset: flags=%b rem=%0d cnt=%0d expected 0000/0/0", {o_busy, o_eject_req, o_done, o_error}, o_remaining, o_coin_count);
        end
        hop_follow = 1'b1;
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_zero();
        test_skip_empty();
        test_back_to_back();
        test_no_tube();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
